// File: rtl/ssp_rx_ctrl.sv
// -----------------------------------------------------------------------------
// ssp_rx_ctrl
//   Receive-side sequencer of the synchronous serial port. It watches the
//   serial bit clock for falling edges, recognises frame syncs, and shifts in
//   DATA_WIDTH-bit words MSB first. Each completed word is written to the
//   receive FIFO with a single-cycle NextWord strobe. A word that completes
//   while the FIFO reports full is dropped, and the sticky RxOverrun flag is
//   set.
//
// Ports
//   PCLK       in   system clock, rising edge
//   CLEAR      in   asynchronous active-high reset
//   SSE        in   port enable; low forces IDLE and discards a partial word
//   SSPCLKIN   in   serial bit clock, already synchronous to PCLK
//   SSPFSSIN   in   frame sync, high for one bit period before the MSB
//   SSPRXD     in   serial data, MSB first
//   RxFull     in   receive FIFO full flag (only looked at on the last bit)
//   OvrClr     in   single-cycle clear of RxOverrun
//   RxData     out  last completed word, held until the next completed word
//   NextWord   out  single-cycle FIFO write strobe
//   RxBusy     out  high while a word is being shifted in
//   RxOverrun  out  sticky: a completed word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module ssp_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  PCLK,
   input  logic                  CLEAR,
   input  logic                  SSE,
   input  logic                  SSPCLKIN,
   input  logic                  SSPFSSIN,
   input  logic                  SSPRXD,
   input  logic                  RxFull,
   input  logic                  OvrClr,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  NextWord,
   output logic                  RxBusy,
   output logic                  RxOverrun
);

   // Counter just wide enough to index DATA_WIDTH bits (at least one bit).
   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  clk_q;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
   logic                  nextword_q, nextword_d;
   logic                  busy_q, busy_d;
   logic                  ovr_q, ovr_d;

   logic                  fall_s;
   logic                  ovr_set_s;
   logic [DATA_WIDTH-1:0] shifted_s;

   // A falling bit-clock edge is seen when the previous sample was high and
   // the current pin value is low; data and sync are sampled on that edge.
   assign fall_s    = clk_q & ~SSPCLKIN;
   assign shifted_s = {shreg_q[DATA_WIDTH-2:0], SSPRXD};

   // Sequencer next-state: frame detection, shifting and word completion.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      rxdata_d   = rxdata_q;
      nextword_d = 1'b0;
      ovr_set_s  = 1'b0;

      if (!SSE) begin
         // Disable wins over everything, including a last-bit fall.
         state_d   = ST_IDLE;
         bit_cnt_d = CNT_ZERO;
      end else if (fall_s) begin
         case (state_q)
            ST_IDLE: begin
               if (SSPFSSIN) begin
                  state_d   = ST_SHIFT;
                  bit_cnt_d = CNT_ZERO;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               shreg_d = shifted_s;
               if (bit_cnt_q == LAST_BIT) begin
                  // Word complete; a sync on this same fall chains straight
                  // into the next frame without an idle bit.
                  bit_cnt_d = CNT_ZERO;
                  state_d   = SSPFSSIN ? ST_SHIFT : ST_IDLE;
                  if (!RxFull) begin
                     rxdata_d   = shifted_s;
                     nextword_d = 1'b1;
                  end else begin
                     ovr_set_s  = 1'b1;
                  end
               end else begin
                  // Mid-word syncs are deliberately ignored: no resync.
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               bit_cnt_d = CNT_ZERO;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Overrun flag: a new drop on the same cycle as a clear keeps it set.
   always_comb begin
      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (OvrClr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Busy tracks the state the sequencer is about to enter.
   always_comb begin
      busy_d = (state_d == ST_SHIFT);
   end

   // State and output registers.
   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         state_q    <= ST_IDLE;
         clk_q      <= 1'b0;
         bit_cnt_q  <= CNT_ZERO;
         shreg_q    <= '0;
         rxdata_q   <= '0;
         nextword_q <= 1'b0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_q      <= SSPCLKIN;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         rxdata_q   <= rxdata_d;
         nextword_q <= nextword_d;
         busy_q     <= busy_d;
         ovr_q      <= ovr_d;
      end
   end

   assign RxData    = rxdata_q;
   assign NextWord  = nextword_q;
   assign RxBusy    = busy_q;
   assign RxOverrun = ovr_q;

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ssp_rx_ctrl
//   Drives serial frames into ssp_rx_ctrl. For each frame the driver works out
//   at frame level what must happen (word to FIFO, overrun, busy) and pushes
//   expected words into a queue; a separate negedge monitor pops and compares
//   on every NextWord strobe and tracks the held outputs every cycle.
// -----------------------------------------------------------------------------
module tb_ssp_rx_ctrl;

   logic       PCLK = 1'b0;
   logic       CLEAR, SSE, SSPCLKIN, SSPFSSIN, SSPRXD, RxFull, OvrClr;
   logic [7:0] RxData;
   logic       NextWord, RxBusy, RxOverrun;

   ssp_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .PCLK(PCLK), .CLEAR(CLEAR), .SSE(SSE), .SSPCLKIN(SSPCLKIN),
      .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD), .RxFull(RxFull), .OvrClr(OvrClr),
      .RxData(RxData), .NextWord(NextWord), .RxBusy(RxBusy),
      .RxOverrun(RxOverrun)
   );

   always #5 PCLK = ~PCLK;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_rxdata = 8'h00;
   logic       exp_ovr    = 1'b0;
   logic       exp_busy   = 1'b0;
   int         cyc        = 0;
   int         nw_count   = 0;
   int         last_nw_cyc = 0;
   int         prev_nw_cyc = 0;
   logic       prev_nw    = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops on every strobe, checks held outputs every cycle.
   always @(negedge PCLK) begin
      cyc++;
      if (!CLEAR) begin
         if (NextWord) begin
            chk("nw_back_to_back", 32'(prev_nw), 32'd0);
            if (exp_q.size() == 0) begin
               chk("nw_unexpected", 32'(RxData), 32'hFFFF_FFFF);
            end else begin
               chk("nw_word", 32'(RxData), 32'(exp_q.pop_front()));
            end
            nw_count++;
            prev_nw_cyc = last_nw_cyc;
            last_nw_cyc = cyc;
         end
         prev_nw = NextWord;
         chk("rxdata_held", 32'(RxData), 32'(exp_rxdata));
         chk("overrun", 32'(RxOverrun), 32'(exp_ovr));
         chk("busy", 32'(RxBusy), 32'(exp_busy));
      end else begin
         prev_nw = 1'b0;
      end
   end

   // One serial bit: h PCLK cycles high, l cycles low. The first low edge is
   // the sampling fall, where the frame-level expectations are applied.
   task automatic serial_bit(input logic fss, input logic d, input int h, input int l,
                             input logic is_sync, input logic last, input logic full,
                             input logic clr, input logic chain, input logic [7:0] w,
                             output logic nw);
      SSPCLKIN = 1'b1;
      SSPFSSIN = fss;
      SSPRXD   = d;
      RxFull   = 1'($urandom_range(0, 1));
      repeat (h) begin @(posedge PCLK); #1; end
      SSPCLKIN = 1'b0;
      RxFull   = full;
      OvrClr   = clr;
      @(posedge PCLK);
      if (clr) exp_ovr = 1'b0;
      if (is_sync) exp_busy = 1'b1;
      if (last) begin
         if (full) begin
            exp_ovr = 1'b1;
         end else begin
            exp_rxdata = w;
            exp_q.push_back(w);
         end
         exp_busy = chain;
      end
      #1;
      OvrClr = 1'b0;
      RxFull = 1'($urandom_range(0, 1));
      @(negedge PCLK);
      nw = NextWord;
      if (l > 1) begin
         repeat (l - 1) @(posedge PCLK);
         #1;
      end
   endtask

   // Frame: optional sync bit, then nbits data bits MSB first.
   task automatic send_frame(input logic [7:0] w, input logic sync, input logic chain,
                             input logic full, input int h, input int l,
                             input int spur_bit, input int clr_bit, input int nbits);
      logic nw;
      if (sync)
         serial_bit(1'b1, 1'($urandom_range(0, 1)), h, l, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w, nw);
      for (int i = 0; i < nbits; i++) begin
         serial_bit((i == 7) ? chain : (i == spur_bit), w[7-i], h, l, 1'b0, (i == 7), full,
                    (i == clr_bit), chain, w, nw);
         if (i == 7) chk("nw_strobe_after_last_fall", 32'(nw), 32'(!full));
      end
   endtask

   task automatic pulse_clr();
      OvrClr = 1'b1;
      @(posedge PCLK);
      exp_ovr = 1'b0;
      #1;
      OvrClr = 1'b0;
   endtask

   task automatic set_sse(input logic v);
      SSE = v;
      @(posedge PCLK);
      if (!v) exp_busy = 1'b0;
      #1;
   endtask

   initial begin
      int   base;
      logic chain_prev;
      CLEAR = 1'b1; SSE = 1'b1; SSPCLKIN = 1'b0; SSPFSSIN = 1'b0;
      SSPRXD = 1'b0; RxFull = 1'b0; OvrClr = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      chk("reset_rxdata", 32'(RxData), 32'd0);
      chk("reset_nextword", 32'(NextWord), 32'd0);
      chk("reset_busy", 32'(RxBusy), 32'd0);
      chk("reset_overrun", 32'(RxOverrun), 32'd0);
      CLEAR = 1'b0;
      repeat (2) begin @(posedge PCLK); #1; end

      // Single frame, bit period 4.
      send_frame(8'hE7, 1'b1, 1'b0, 1'b0, 2, 2, -1, -1, 8);
      repeat (4) begin @(posedge PCLK); #1; end
      chk("single_rxdata", 32'(RxData), 32'hE7);

      // Back-to-back frames, strobes 32 cycles apart.
      send_frame(8'h3A, 1'b1, 1'b1, 1'b0, 2, 2, -1, -1, 8);
      send_frame(8'h29, 1'b0, 1'b0, 1'b0, 2, 2, -1, -1, 8);
      chk("b2b_spacing", 32'(last_nw_cyc - prev_nw_cyc), 32'd32);
      repeat (3) begin @(posedge PCLK); #1; end

      // Overrun, clear, then clear coincident with a new overrun.
      send_frame(8'hC5, 1'b1, 1'b0, 1'b1, 2, 2, -1, -1, 8);
      chk("ovr_rxdata_kept", 32'(RxData), 32'h29);
      chk("ovr_set", 32'(RxOverrun), 32'd1);
      pulse_clr();
      @(negedge PCLK);
      chk("ovr_cleared", 32'(RxOverrun), 32'd0);
      send_frame(8'h66, 1'b1, 1'b0, 1'b1, 1, 1, -1, 7, 8);
      @(negedge PCLK);
      chk("ovr_set_wins", 32'(RxOverrun), 32'd1);
      pulse_clr();

      // Spurious sync at bit 3.
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1, 2, 3, -1, 8);
      repeat (3) begin @(posedge PCLK); #1; end
      chk("spur_rxdata", 32'(RxData), 32'h81);

      // Disable after 4 bits, re-enable, full frame.
      base = nw_count;
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 2, 2, -1, -1, 4);
      set_sse(1'b0);
      repeat (3) begin @(posedge PCLK); #1; end
      set_sse(1'b1);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 2, 2, -1, -1, 8);
      repeat (3) begin @(posedge PCLK); #1; end
      chk("disable_one_word", 32'(nw_count - base), 32'd1);
      chk("disable_rxdata", 32'(RxData), 32'h5A);

      // Randomized frames.
      chain_prev = 1'b0;
      for (int f = 0; f < 40; f++) begin
         logic c;
         c = (f == 39) ? 1'b0 : 1'($urandom_range(0, 1));
         send_frame(8'($urandom), !chain_prev, c, ($urandom_range(0, 3) == 0),
                    $urandom_range(1, 3), $urandom_range(1, 3),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1, 8);
         if (!c && $urandom_range(0, 3) == 0) pulse_clr();
         chain_prev = c;
      end
      repeat (3) begin @(posedge PCLK); #1; end

      // Asynchronous reset mid-word with known non-zero outputs beforehand.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1, 1, -1, -1, 8);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1, 1, -1, -1, 8);
      send_frame(8'h77, 1'b1, 1'b0, 1'b0, 2, 2, -1, -1, 3);
      chk("pre_reset_busy", 32'(RxBusy), 32'd1);
      @(posedge PCLK);
      #3;
      CLEAR = 1'b1;
      #1;
      chk("async_reset_rxdata", 32'(RxData), 32'd0);
      chk("async_reset_busy", 32'(RxBusy), 32'd0);
      chk("async_reset_overrun", 32'(RxOverrun), 32'd0);
      chk("async_reset_nextword", 32'(NextWord), 32'd0);
      exp_rxdata = 8'h00; exp_ovr = 1'b0; exp_busy = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         @(posedge PCLK); #1; SSPCLKIN = ~SSPCLKIN;
      end
      SSPCLKIN = 1'b0;
      @(posedge PCLK);
      #3;
      CLEAR = 1'b0;
      @(posedge PCLK);
      #1;
      send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1, 2, -1, -1, 8);
      repeat (3) begin @(posedge PCLK); #1; end
      chk("post_reset_rxdata", 32'(RxData), 32'h96);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ssp_rx_ctrl.md
# ssp_rx_ctrl

Receive-side sequencer of the SSP. It detects frame syncs on the serial input pins and deserialises each 8-bit word, MSB first. It then pushes the word into the receive FIFO with a one-cycle `NextWord` strobe on `RxData`. A word that arrives while the FIFO is full is dropped and recorded as an overrun. The block sits between the SSP pins (already synchronous to `PCLK`) and `rx_fifo`.

## Interface
- `DATA_WIDTH`, 8, bits per serial frame; also the width of `RxData` and the shift register.
- `PCLK` input 1: system clock; all state updates on its rising edge.
- `CLEAR` input 1: asynchronous, active-high reset.
- `SSE` input 1: port enable; 0 forces IDLE and discards any partial word.
- `SSPCLKIN` input 1: serial bit clock, synchronous to `PCLK`, high ≥1 and low ≥1 `PCLK` cycle.
- `SSPFSSIN` input 1: frame sync, high for one `SSPCLKIN` period before the MSB.
- `SSPRXD` input 1: serial data, MSB first.
- `RxFull` input 1: receive FIFO full flag.
- `OvrClr` input 1: one-cycle clear of `RxOverrun`.
- `RxData` output DATA_WIDTH: last completed word; stable until the next completed word.
- `NextWord` output 1: one-`PCLK` write strobe to `rx_fifo`.
- `RxBusy` output 1: high while in SHIFT.
- `RxOverrun` output 1: sticky; a completed word was dropped because `RxFull` was 1.

## Operation
- **Edge detect:**
  - `clk_q` registers `SSPCLKIN`.
  - `fall` is `clk_q`=1 and `SSPCLKIN`=0 at a `PCLK` rising edge.
  - `SSPRXD` and `SSPFSSIN` are sampled on that same edge.
  - All actions below happen only on `fall` cycles unless stated otherwise.
- **State IDLE:**
  - `fall` with `SSPFSSIN`=1 → SHIFT, `bit_cnt`=0.
  - Otherwise stay in IDLE.
- **State SHIFT:**
  - Each `fall`: `shreg` ← {`shreg`[DATA_WIDTH-2:0], `SSPRXD`}; `bit_cnt` increments.
  - On the fall where `bit_cnt`=DATA_WIDTH-1 (last bit), the word completes:
    - If `RxFull`=0: `RxData` ← completed word (shift value including this bit); `NextWord`=1 on the next cycle.
    - If `RxFull`=1: `RxData` and the FIFO are unchanged; `RxOverrun` ← 1.
    - Next state: SHIFT with `bit_cnt`=0 if `SSPFSSIN`=1 on this same fall (back-to-back frame); else IDLE.
  - `SSPFSSIN`=1 on a fall before the last bit is ignored. There is no resync mid-word.
- **`SSE`=0 (any cycle):**
  - State goes to IDLE and `bit_cnt` to 0; `shreg` contents become don't-care.
  - No `NextWord` is generated, even on a last-bit fall.
  - `RxData` and `RxOverrun` are held.
- **`RxOverrun`:**
  - Set per above; cleared by `OvrClr`=1.
  - Simultaneous set and clear → set wins.
  - `SSE`=0 does not clear it.
- **`bit_cnt`** is ceil(log2(DATA_WIDTH)) bits wide and never exceeds DATA_WIDTH-1.

## Timing
- **Reset values:** IDLE; `clk_q`=0; `bit_cnt`=0; `shreg`=0; `RxData`=0; `NextWord`=0; `RxBusy`=0; `RxOverrun`=0.
- **Reset mid-word:** partial word lost; no `NextWord`.
- **Word latency:** the last-bit fall is detected at `PCLK` edge k. `RxData` is updated and `NextWord`=1 from edge k, visible in cycle k+1 only. `NextWord` is 0 again after edge k+1.
- **`NextWord`** is never high for two consecutive cycles. The minimum spacing is 2·DATA_WIDTH `PCLK` cycles, given the minimum `SSPCLKIN` period of 2 cycles.
- **`RxBusy`** rises in the cycle after the frame-sync fall. It stays high through back-to-back frames and falls in the cycle after the last-bit fall when no new sync is seen.
- **`RxFull`** is sampled on the last-bit fall edge only.
- **`RxOverrun`** is registered: it rises in the cycle after the dropping fall.

## Test plan
- **Reset:** assert `CLEAR` mid-cycle with `SSPCLKIN` toggling → all outputs 0 immediately (asynchronous); release; state IDLE.
- **Single frame:** `SSE`=1, FSS pulse, then bits of 0xE7 MSB first, `SSPCLKIN` period 4 `PCLK` cycles → `RxData`=0xE7, `NextWord` high exactly one cycle after the 8th fall, `RxOverrun`=0, `RxBusy` low afterwards.
- **Back-to-back:** FSS high on the 8th fall of 0x3A, then 0x29 → two `NextWord` pulses 32 `PCLK` cycles apart carrying 0x3A then 0x29; `RxBusy` stays high throughout.
- **Overrun:** `RxFull`=1 during the 8th fall of 0xC5 → no `NextWord`; `RxData` keeps its prior value; `RxOverrun`=1. Pulse `OvrClr` → 0. `OvrClr` coincident with a new overrun → `RxOverrun` stays 1.
- **Disable mid-word:** drop `SSE` after 4 bits, re-enable, send a full frame 0x5A → only one `NextWord`, with `RxData`=0x5A.
- **Spurious sync:** FSS pulse at bit 3 of 0x81 → ignored; `RxData`=0x81; returns to IDLE.
